agdc_door_model: RTL and testbench

//  Door-side counterpart of the AGDC Moore controller: turns the motor commands UP_M/DN_M

---
 rtl/agdc_door_model.sv | 96 +++++++++
 tb/tb_agdc_door_model.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/agdc_door_model.sv
// rtl/agdc_door_model.sv - door/limit-switch model driven by AGDC motor commands
module agdc_door_model #(
    parameter int TRAVEL    = 10,
    parameter int POS_W     = 4,
    parameter int RESET_POS = 0,
    parameter int REV_DELAY = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             DN_M,
    output logic             UP_Max,
    output logic             DN_Max,
    output logic [POS_W-1:0] Pos,
    output logic             Moving,
    output logic             Fault
);

    localparam int DW = (REV_DELAY < 1) ? 1 : $clog2(REV_DELAY + 1);
    localparam logic [POS_W-1:0] TRAVEL_P = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] RESET_P  = POS_W'(RESET_POS);
    localparam logic [DW-1:0]    DEAD_LD  = DW'(REV_DELAY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RISING  = 2'd1,
        S_FALLING = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t          state;
    logic [DW-1:0]   dead;

    assign UP_Max = (Pos == TRAVEL_P);
    assign DN_Max = (Pos == '0);

    // Simultaneous drive wins over everything else; Moving/Fault are registered with the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            Pos    <= RESET_P;
            dead   <= '0;
            Moving <= 1'b0;
            Fault  <= 1'b0;
        end else if (UP_M && DN_M) begin
            state  <= S_FAULT;
            Moving <= 1'b0;
            Fault  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dead != '0) begin
                        dead <= dead - 1'b1;
                    end else if (UP_M && (Pos < TRAVEL_P)) begin
                        state  <= S_RISING;
                        Moving <= 1'b1;
                    end else if (DN_M && (Pos > '0)) begin
                        state  <= S_FALLING;
                        Moving <= 1'b1;
                    end
                end
                S_RISING: begin
                    if (UP_M && (Pos < TRAVEL_P)) begin
                        Pos <= Pos + 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        Moving <= 1'b0;
                        dead   <= DEAD_LD;
                    end
                end
                S_FALLING: begin
                    if (DN_M && (Pos > '0)) begin
                        Pos <= Pos - 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        Moving <= 1'b0;
                        dead   <= DEAD_LD;
                    end
                end
                S_FAULT: begin
                    if (!UP_M && !DN_M) begin
                        state <= S_IDLE;
                        Fault <= 1'b0;
                        dead  <= DEAD_LD;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    Moving <= 1'b0;
                    Fault  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agdc_door_model.sv
// tb/tb_agdc_door_model.sv - directed scoreboard bench for agdc_door_model
module tb_agdc_door_model;

    logic       CLK;
    logic       RST;
    logic       UP_M;
    logic       DN_M;
    logic       UP_Max;
    logic       DN_Max;
    logic [3:0] Pos;
    logic       Moving;
    logic       Fault;

    int vectors;
    int miscompares;

    typedef struct {
        string      tag;
        logic [3:0] pos;
        logic       moving;
        logic       fault;
    } exp_t;

    exp_t sb[$];

    agdc_door_model #(
        .TRAVEL   (10),
        .POS_W    (4),
        .RESET_POS(0),
        .REV_DELAY(2)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .UP_M  (UP_M),
        .DN_M  (DN_M),
        .UP_Max(UP_Max),
        .DN_Max(DN_Max),
        .Pos   (Pos),
        .Moving(Moving),
        .Fault (Fault)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".pos"},    {4'd0, Pos},    {4'd0, e.pos});
            chk({e.tag, ".moving"}, {7'd0, Moving}, {7'd0, e.moving});
            chk({e.tag, ".fault"},  {7'd0, Fault},  {7'd0, e.fault});
            chk({e.tag, ".up_max"}, {7'd0, UP_Max}, {7'd0, (e.pos == 4'd10)});
            chk({e.tag, ".dn_max"}, {7'd0, DN_Max}, {7'd0, (e.pos == 4'd0)});
        end
    endtask

    // Drive commands, record what the next edge must produce, then check #1 after that edge.
    task automatic step(input string tag, input logic up, input logic dn,
                        input logic [3:0] pos, input logic moving, input logic fault);
        exp_t e;
        UP_M = up;
        DN_M = dn;
        e.tag = tag; e.pos = pos; e.moving = moving; e.fault = fault;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        pop_and_check();
    endtask

    task automatic now_check(input string tag, input logic [3:0] pos,
                             input logic moving, input logic fault);
        exp_t e;
        e.tag = tag; e.pos = pos; e.moving = moving; e.fault = fault;
        sb.push_back(e);
        pop_and_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        UP_M = 1'b0;
        DN_M = 1'b0;
        RST  = 1'b0;

        #5;
        now_check("reset", 4'd0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Full open from closed position
        step("open_e1", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++)
            step("open_run", 1'b1, 1'b0, 4'(k), 1'b1, 1'b0);
        step("open_limit", 1'b1, 1'b0, 4'd10, 1'b0, 1'b0);

        // Reversal: two dead edges then fall
        step("rev_dead1", 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        step("rev_dead2", 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        step("rev_start", 1'b0, 1'b1, 4'd10, 1'b1, 1'b0);
        for (int k = 9; k >= 0; k--)
            step("close_run", 1'b0, 1'b1, 4'(k), 1'b1, 1'b0);
        step("close_limit", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            step("close_hold", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Partial stop at Pos 5
        step("part_start", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++)
            step("part_run", 1'b1, 1'b0, 4'(k), 1'b1, 1'b0);
        step("part_stop", 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        step("part_dead1", 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        step("part_dead2", 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);

        // Fault mid-travel at Pos 4
        step("fall_start", 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        step("fall_to4", 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        step("fault_set", 1'b1, 1'b1, 4'd4, 1'b0, 1'b1);
        step("fault_hold", 1'b1, 1'b1, 4'd4, 1'b0, 1'b1);
        step("fault_single", 1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
        step("fault_clear", 1'b0, 1'b0, 4'd4, 1'b0, 1'b0);
        step("fault_block1", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
        step("fault_block2", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
        step("fault_restart", 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        step("rise_to5", 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
        step("rise_to6", 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);

        // Asynchronous reset between edges mid-rise
        #4;
        RST = 1'b0;
        #1;
        now_check("async_reset", 4'd0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        now_check("reset_held", 4'd0, 1'b0, 1'b0);
        UP_M = 1'b0;
        RST  = 1'b1;
        step("post_reset", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
